// File: rtl/avalon_pio_out_blink.sv
// Avalon-MM output PIO with atomic bit set/clear and a per-bit hardware blink engine.
// Blinking only blanks out_port; DATA always reads back the unblanked value.
module avalon_pio_out_blink #(
    parameter int                    DATA_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    DIV_WIDTH   = 24,
    parameter logic [DIV_WIDTH-1:0]  DIV_RESET   = DIV_WIDTH'(12499999)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_DIV    = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] blink_mask_q;
    logic [DIV_WIDTH-1:0]  blink_div_q;
    logic [DIV_WIDTH-1:0]  counter_q;
    logic                  en_q;
    logic                  phase_q;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  unused_writedata;

    assign wr               = chipselect && !write_n;
    assign wr_data          = writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE;
            blink_mask_q <= '0;
            blink_div_q  <= DIV_RESET;
            en_q         <= 1'b0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data_q       <= wr_data;
                ADDR_MASK:   blink_mask_q <= wr_data;
                ADDR_DIV:    blink_div_q  <= writedata[DIV_WIDTH-1:0];
                ADDR_CTRL:   en_q         <= writedata[0];
                ADDR_OUTSET: data_q       <= data_q | wr_data;
                ADDR_OUTCLR: data_q       <= data_q & ~wr_data;
                default:     ;
            endcase
        end
    end

    // Disabling wins over a simultaneous terminal count; a divider write restarts
    // the count so a smaller new divider never waits for a full counter wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= '0;
            phase_q   <= 1'b0;
        end else if (!en_q || (wr && address == ADDR_CTRL && !writedata[0])) begin
            counter_q <= '0;
            phase_q   <= 1'b0;
        end else if (wr && address == ADDR_DIV) begin
            counter_q <= '0;
        end else if (counter_q == blink_div_q) begin
            counter_q <= '0;
            phase_q   <= ~phase_q;
        end else begin
            counter_q <= counter_q + 1'b1;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[DATA_WIDTH-1:0] = data_q;
            ADDR_MASK: readdata[DATA_WIDTH-1:0] = blink_mask_q;
            ADDR_DIV:  readdata[DIV_WIDTH-1:0]  = blink_div_q;
            ADDR_CTRL: readdata[1:0]            = {phase_q, en_q};
            default:   readdata = '0;
        endcase
    end

    assign out_port = data_q & ~(blink_mask_q & {DATA_WIDTH{en_q & phase_q}});

endmodule

// File: tb/tb_avalon_pio_out_blink.sv
// Directed self-checking bench for avalon_pio_out_blink (4-bit, reset value 4'hA).
module tb_avalon_pio_out_blink;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int errors;
    int checks;

    avalon_pio_out_blink #(
        .DATA_WIDTH  (4),
        .RESET_VALUE (4'hA),
        .DIV_WIDTH   (24),
        .DIV_RESET   (24'd12499999)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bus write; returns 1 ns after the edge that performed it.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readCheck(input string tag, input logic [2:0] addr, input logic [31:0] expected);
        @(negedge clk);
        address = addr;
        #1;
        checkOutput(tag, readdata, expected);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("reset_out", {28'd0, out_port}, 32'hA);
        readCheck("reset_data", 3'd0, 32'h0000_000A);
        readCheck("reset_div", 3'd2, 32'd12499999);
        readCheck("reset_ctrl", 3'd3, 32'd0);

        applyStimulus(3'd0, 32'hFFFF_FFF5);
        checkOutput("data_wr_out", {28'd0, out_port}, 32'h5);
        readCheck("data_rd", 3'd0, 32'h5);
        applyStimulus(3'd4, 32'h2);
        checkOutput("outset_out", {28'd0, out_port}, 32'h7);
        applyStimulus(3'd5, 32'h5);
        checkOutput("outclr_out", {28'd0, out_port}, 32'h2);
        readCheck("outset_rd", 3'd4, 32'd0);
        readCheck("outclr_rd", 3'd5, 32'd0);
        readCheck("reserved_rd", 3'd6, 32'd0);

        // Divider 3 gives four cycles per phase; mask 3 blanks the low two bits.
        applyStimulus(3'd2, 32'd3);
        applyStimulus(3'd1, 32'h3);
        applyStimulus(3'd0, 32'hF);
        readCheck("mask_rd", 3'd1, 32'h3);
        applyStimulus(3'd3, 32'h1);
        address = 3'd3;
        #1;
        checkOutput("en_out", {28'd0, out_port}, 32'hF);
        checkOutput("en_ctrl", readdata, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            checkOutput("blink_out", {28'd0, out_port}, ((k % 8) >= 4) ? 32'hC : 32'hF);
            checkOutput("blink_ctrl", readdata, ((k % 8) >= 4) ? 32'h3 : 32'h1);
        end

        applyStimulus(3'd3, 32'h0);
        address = 3'd3;
        #1;
        checkOutput("disable_out", {28'd0, out_port}, 32'hF);
        checkOutput("disable_ctrl", readdata, 32'h0);

        applyStimulus(3'd3, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("reenable_out", {28'd0, out_port}, (k == 4) ? 32'hC : 32'hF);
        end

        // Divider 0 toggles the phase on every edge.
        applyStimulus(3'd3, 32'h0);
        applyStimulus(3'd1, 32'h1);
        applyStimulus(3'd0, 32'h1);
        applyStimulus(3'd2, 32'h0);
        applyStimulus(3'd3, 32'h1);
        checkOutput("div0_start", {28'd0, out_port}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("div0_out", {28'd0, out_port}, (k % 2 == 1) ? 32'h0 : 32'h1);
        end

        // Counter reaches 5 under divider 9, then divider 2 is written.
        applyStimulus(3'd3, 32'h0);
        applyStimulus(3'd2, 32'd9);
        applyStimulus(3'd3, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("div9_no_toggle", {28'd0, out_port}, 32'h1);
        applyStimulus(3'd2, 32'd2);
        checkOutput("divwr_out", {28'd0, out_port}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("divwr_toggle", {28'd0, out_port}, (k == 3) ? 32'h0 : 32'h1);
        end

        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out", {28'd0, out_port}, 32'hA);
        readCheck("midreset_ctrl", 3'd3, 32'd0);
        readCheck("midreset_data", 3'd0, 32'hA);
        @(negedge clk);
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_pio_out_blink.md
Name: avalon_pio_out_blink

Overview:
- Parametrised Avalon-MM output PIO for the alarm clock display and indicator outputs; successor to the fixed 4-bit digit output ports.
- Adds a configurable width, atomic bit set/clear registers, and a hardware blink engine.
- A per-bit blink mask blanks selected outputs at a programmable rate, for example a flashing digit while the alarm time is being set, with no CPU polling.

Parameters:
- DATA_WIDTH, 4, width of out_port and of the DATA/BLINK_MASK registers (1..32).
- RESET_VALUE, 0, reset value of DATA.
- DIV_WIDTH, 24, width of the blink divider register and counter (1..32).
- DIV_RESET, 12499999, reset value of BLINK_DIV (2 Hz blink at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-extended.
- out_port  out  DATA_WIDTH  driven outputs.

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk. Reset is applied immediately, including mid-operation. Reset values:
  - DATA = RESET_VALUE
  - BLINK_MASK = 0
  - BLINK_DIV = DIV_RESET
  - EN = 0, PHASE = 0, counter = 0
  - out_port = RESET_VALUE
- Write qualifier: chipselect && !write_n, sampled at posedge clk. Writes take effect at that edge.
- Register map:
  - 0 DATA: read/write, writedata[DATA_WIDTH-1:0].
  - 1 BLINK_MASK: read/write.
  - 2 BLINK_DIV: read/write, writedata[DIV_WIDTH-1:0].
  - 3 CTRL: bit0 EN read/write; bit1 PHASE read-only (writes ignored).
  - 4 OUTSET: write-only; DATA <= DATA | writedata[DATA_WIDTH-1:0]; reads 0.
  - 5 OUTCLR: write-only; DATA <= DATA & ~writedata[DATA_WIDTH-1:0]; reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Reads:
  - Combinational from address, zero wait states, no chipselect/read_n gating.
  - Unused upper bits read 0.
- Blink engine, EN=1:
  - Counter increments every clk.
  - When counter == BLINK_DIV: counter <= 0 and PHASE toggles.
  - Half-period is BLINK_DIV+1 cycles. BLINK_DIV=0 toggles PHASE every cycle.
- Blink engine, EN=0:
  - Counter held at 0 and PHASE held at 0.
  - A write of EN=0 on the same edge as a terminal count takes priority: PHASE=0, counter=0.
- Transitions:
  - EN 0->1: first PHASE toggle occurs BLINK_DIV+1 edges after the enabling write edge.
  - Write to BLINK_DIV: counter <= 0 on the same edge; PHASE unchanged. New value is used from the next cycle.
  - If the counter already exceeds a newly written smaller divider, the counter reset applies, so there is no long wrap.
- Output: out_port = DATA & ~(BLINK_MASK & {DATA_WIDTH{EN & PHASE}}).
  - Combinational from flops only; no added latency.
  - A write at edge N is visible on out_port after edge N.
- OUTSET/OUTCLR: atomic read-modify-write. Only one bus access per cycle, so no set/clear collision is possible.
- Masked bits blank to 0 while PHASE=1. Unmasked bits always follow DATA. DATA reads back the unblanked value.

Test Plan:
- Reset release with RESET_VALUE=4'hA: out_port=4'hA; readdata at addr 0=0xA, addr 2=DIV_RESET, addr 3=0. Assert reset_n mid-blink -> out_port=RESET_VALUE and PHASE=0 immediately.
- Write DATA=0xFFFFFFF5 -> out_port=4'h5, addr 0 reads 0x5. OUTSET 0x2 -> 4'h7. OUTCLR 0x5 -> 4'h2. Addr 4/5/6 read 0.
- BLINK_DIV=3, BLINK_MASK=4'h3, DATA=4'hF, CTRL=1:
  - out_port=F for 4 cycles, then 4'hC for 4 cycles, repeating.
  - CTRL bit1 tracks the phase.
- During blanked phase write CTRL=0 -> next cycle out_port=4'hF, PHASE=0. Re-enable -> first toggle exactly 4 cycles later.
- BLINK_DIV=0 with EN=1, mask=4'h1, DATA=4'h1 -> out_port alternates 1,0 every cycle.
- Write BLINK_DIV=2 while counter=5 under old divider 9 -> counter restarts. Next toggle occurs 3 cycles after the write edge.
